// File: rtl/tap_delay_ring.sv
// Multi-tap programmable delay line over a circular sample buffer; one sample in per en.
// Latency 1 clk from en to tap_out/out_valid; no backpressure, en may be high every cycle.
module tap_delay_ring #(
    parameter int SIG_WIDTH  = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_TAPS   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic [SIG_WIDTH-1:0]           sr_in,
    input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tap_dly,
    output logic [NUM_TAPS*SIG_WIDTH-1:0]  tap_out,
    output logic [NUM_TAPS-1:0]            tap_valid,
    output logic                           out_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = {ADDR_WIDTH{1'b1}};

    // Sample history; deliberately not reset, fill_cnt hides stale entries.
    logic [SIG_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0]          wp_q, wp_d;
    logic [ADDR_WIDTH-1:0]          fill_cnt_q, fill_cnt_d;
    logic [NUM_TAPS*SIG_WIDTH-1:0]  tap_out_q, tap_out_d;
    logic [NUM_TAPS-1:0]            tap_valid_q, tap_valid_d;
    logic                           out_valid_q, out_valid_d;
    logic                           mem_we;

    logic [ADDR_WIDTH-1:0] tap_d   [NUM_TAPS];
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_TAPS];
    logic [SIG_WIDTH-1:0]  rd_dat  [NUM_TAPS];

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            tap_d[k]   = tap_dly[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_addr[k] = wp_q - tap_d[k];
            rd_dat[k]  = mem[rd_addr[k]];
        end
    end

    always_comb begin
        wp_d        = wp_q;
        fill_cnt_d  = fill_cnt_q;
        tap_out_d   = tap_out_q;
        tap_valid_d = tap_valid_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        if (clr) begin
            wp_d        = '0;
            fill_cnt_d  = '0;
            tap_out_d   = '0;
            tap_valid_d = '0;
        end else if (en) begin
            mem_we      = 1'b1;
            wp_d        = wp_q + ADDR_ONE;
            out_valid_d = 1'b1;
            if (fill_cnt_q != FILL_MAX) begin
                fill_cnt_d = fill_cnt_q + ADDR_ONE;
            end
            // Reads use the pre-edge pointer and fill count; d == 0 bypasses the RAM.
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (tap_d[k] == '0) begin
                    tap_out_d[k*SIG_WIDTH +: SIG_WIDTH] = sr_in;
                    tap_valid_d[k]                      = 1'b1;
                end else if (tap_d[k] <= fill_cnt_q) begin
                    tap_out_d[k*SIG_WIDTH +: SIG_WIDTH] = rd_dat[k];
                    tap_valid_d[k]                      = 1'b1;
                end else begin
                    tap_out_d[k*SIG_WIDTH +: SIG_WIDTH] = '0;
                    tap_valid_d[k]                      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            fill_cnt_q  <= '0;
            tap_out_q   <= '0;
            tap_valid_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            fill_cnt_q  <= fill_cnt_d;
            tap_out_q   <= tap_out_d;
            tap_valid_q <= tap_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wp_q] <= sr_in;
        end
    end

    assign tap_out   = tap_out_q;
    assign tap_valid = tap_valid_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tap_delay_ring.sv
// Directed and randomized bench for tap_delay_ring against a sample-history delay model.
module tb_tap_delay_ring;

    localparam int SW = 16;
    localparam int AW = 9;
    localparam int NT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clr = 1'b0;
    logic               en = 1'b0;
    logic [SW-1:0]      sr_in = '0;
    logic [NT*AW-1:0]   tap_dly = '0;
    logic [NT*SW-1:0]   tap_out;
    logic [NT-1:0]      tap_valid;
    logic               out_valid;

    int tests = 0;
    int fails = 0;

    // Model: every sample accepted since the last reset/clr, oldest first.
    logic [SW-1:0]      hist[$];
    int                 dly[NT];
    logic [NT*SW-1:0]   exp_bus = '0;
    logic [NT-1:0]      exp_vld = '0;

    tap_delay_ring #(.SIG_WIDTH(SW), .ADDR_WIDTH(AW), .NUM_TAPS(NT)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .sr_in(sr_in),
        .tap_dly(tap_dly), .tap_out(tap_out), .tap_valid(tap_valid),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_taps(input int t0, input int t1, input int t2, input int t3);
        dly[0] = t0; dly[1] = t1; dly[2] = t2; dly[3] = t3;
        tap_dly = {AW'(t3), AW'(t2), AW'(t1), AW'(t0)};
    endtask

    task automatic forget_history();
        hist.delete();
        exp_bus = '0;
        exp_vld = '0;
    endtask

    // Output k after sample n is sample n-d, or zero/invalid when n-d < 0.
    task automatic send(input logic [SW-1:0] v);
        int n;
        int idx;
        clr = 1'b0; en = 1'b1; sr_in = v;
        @(posedge clk); #1;
        hist.push_back(v);
        n = hist.size() - 1;
        for (int k = 0; k < NT; k++) begin
            idx = n - dly[k];
            if (idx >= 0) begin
                exp_bus[k*SW +: SW] = hist[idx];
                exp_vld[k]          = 1'b1;
            end else begin
                exp_bus[k*SW +: SW] = '0;
                exp_vld[k]          = 1'b0;
            end
        end
        check("tap_out", 64'(tap_out), 64'(exp_bus));
        check("tap_valid", 64'(tap_valid), 64'(exp_vld));
        check("out_valid", 64'(out_valid), 64'd1);
        en = 1'b0;
    endtask

    task automatic idle();
        en = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_hold_out", 64'(tap_out), 64'(exp_bus));
        check("idle_hold_vld", 64'(tap_valid), 64'(exp_vld));
    endtask

    task automatic do_clr(input logic with_en, input logic [SW-1:0] v);
        clr = 1'b1; en = with_en; sr_in = v;
        @(posedge clk); #1;
        clr = 1'b0; en = 1'b0;
        forget_history();
        check("clr_out", 64'(tap_out), 64'd0);
        check("clr_vld", 64'(tap_valid), 64'd0);
        check("clr_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        set_taps(0, 0, 0, 0);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 64'(tap_out), 64'd0);
        check("rst_vld", 64'(tap_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        forget_history();

        // Ramp through taps {0,1,7,511}
        set_taps(0, 1, 7, 511);
        for (int i = 1; i <= 8; i++) send(SW'(i));
        check("ramp8_out", 64'(tap_out), {16'd0, 16'd1, 16'd7, 16'd8});
        check("ramp8_vld", 64'(tap_valid), 64'h7);
        idle();

        // clr with en high drops the sample, then a fresh start
        for (int i = 9; i <= 20; i++) send(SW'(i));
        do_clr(1'b1, 16'h0099);
        set_taps(0, 1, 2, 3);
        send(16'd5);
        check("clr5_out", 64'(tap_out), {16'd0, 16'd0, 16'd0, 16'd5});
        check("clr5_vld", 64'(tap_valid), 64'h1);

        // Wrap and fill saturation
        do_clr(1'b0, 16'h0000);
        set_taps(511, 256, 128, 1);
        for (int i = 0; i < 1000; i++) begin
            send(SW'(i + 1));
            if (i == 510) check("d511_invalid_at_511", 64'(tap_valid[0]), 64'd0);
            if (i == 511) begin
                check("d511_valid_at_512", 64'(tap_valid[0]), 64'd1);
                check("d511_first_value", 64'(tap_out[SW-1:0]), 64'd1);
            end
        end
        check("wrap_out", 64'(tap_out), {16'd999, 16'd872, 16'd744, 16'd489});
        check("wrap_vld", 64'(tap_valid), 64'hF);

        // Retune tap0 3 -> 10 between en pulses
        do_clr(1'b0, 16'h0000);
        set_taps(3, 5, 50, 49);
        for (int i = 1; i <= 50; i++) send(SW'(i));
        check("retune_before", 64'(tap_out[SW-1:0]), 64'd47);
        set_taps(10, 5, 50, 49);
        idle();
        check("retune_held", 64'(tap_out[SW-1:0]), 64'd47);
        send(16'd51);
        check("retune_after", 64'(tap_out[SW-1:0]), 64'd41);

        // Asynchronous reset away from any clock edge
        send(16'd52);
        rst = 1'b1;
        #1;
        check("arst_out", 64'(tap_out), 64'd0);
        check("arst_vld", 64'(tap_valid), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        forget_history();
        set_taps(3, 7, 2, 0);
        for (int i = 1; i <= 4; i++) begin
            send(SW'(100 + i));
            if (i == 3) check("arst_tap3_invalid", 64'(tap_valid[0]), 64'd0);
            if (i == 4) begin
                check("arst_tap3_valid", 64'(tap_valid[0]), 64'd1);
                check("arst_tap3_value", 64'(tap_out[SW-1:0]), 64'd101);
            end
        end

        // Gapped random data, taps retuned in the gaps
        do_clr(1'b0, 16'h0000);
        set_taps($urandom_range(0, 20), $urandom_range(0, 20),
                 $urandom_range(0, 20), $urandom_range(0, 20));
        for (int i = 0; i < 60; i++) begin
            send(SW'($urandom));
            idle();
            if (i % 10 == 9) begin
                set_taps($urandom_range(0, 30), $urandom_range(0, 30),
                         $urandom_range(0, 511), $urandom_range(0, 30));
            end
            idle();
            idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
